sync_fifo_flex: RTL and testbench
=================================

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, entries (>=2; need not be a power of two).
REQ-003 Parameter FWFT, default 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
REQ-004 Parameter AFULL_TH, default DEPTH-4, almost_full threshold (1..DEPTH).
REQ-005 Parameter AEMPTY_TH, default 4, almost_empty threshold (0..DEPTH-1).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 clr  input  1  synchronous flush, active-high.
REQ-009 wr_en  input  1  write request.
REQ-010 din  input  WIDTH  write data.
REQ-011 full / almost_full  output  1 each  count==DEPTH / count>=AFULL_TH.
REQ-012 rd_en  input  1  read request (FWFT=1: pop of presented word).
REQ-013 dout  output  WIDTH  read data.
REQ-014 valid  output  1  dout holds a valid word this cycle.
REQ-015 empty / almost_empty  output  1 each  count==0 / count<=AEMPTY_TH.
REQ-016 count  output  CW  occupancy 0..DEPTH, CW = clog2(DEPTH+1).
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 Write accepted iff wr_en && (!full || read accepted same cycle); read accepted iff rd_en && !empty.
REQ-019 Accepted write stores din at wr_ptr; pointer advances, DEPTH-1 wraps to 0.
REQ-020 Accepted read advances rd_ptr with identical wrap rule.
REQ-021 count: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH or goes below 0.
REQ-022 Full with simultaneous rd_en and wr_en: both accepted, count stays DEPTH, full stays 1.
REQ-023 Empty with simultaneous rd_en and wr_en: write accepted, read rejected, underflow set, count becomes 1.
REQ-024 All status flags are combinational decodes of registered count only; no input-to-flag paths.
REQ-025 FWFT=0: dout registers mem[rd_ptr] on accepted read, valid=1 the following cycle only; dout holds last value otherwise.
REQ-026 FWFT=1: dout = mem[rd_ptr], valid = !empty; word written into empty FIFO appears the cycle after the write edge.
REQ-027 overflow sets on wr_en with write rejected; underflow sets on rd_en with empty; both hold until rst or clr.
REQ-028 clr: pointers, count, valid, overflow, underflow -> 0 next edge; wr_en/rd_en that cycle ignored and not flagged; memory untouched.
REQ-029 Priority: rst > clr > normal operation.

Reset
REQ-030 After rst: count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, dout=0, overflow=0, underflow=0, pointers=0.
REQ-031 rst mid-operation discards all stored words; the next write is read back first.
REQ-032 Memory contents need no reset.

Structure
REQ-033 Package fifo_pkg holds FIFO_MODE_STD=0, FIFO_MODE_FWFT=1 constants and the count-width function.
REQ-034 Storage is sub-module fifo_ram (1 write port, 1 asynchronous read port, WIDTH x DEPTH), no reset.
REQ-035 Pointer/count control and flag decode live in sync_fifo_flex; parameter ranges checked at elaboration.

Verification
REQ-036 DEPTH=4, FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4; 5th write -> overflow=1, contents unchanged; four reads -> dout 0x11..0x44, each valid one cycle after rd_en.
REQ-037 DEPTH=5 (non-pow2): 12 writes interleaved with reads -> data order preserved across pointer wrap 4->0, count never >5.
REQ-038 Full, rd_en=wr_en=1 with din=0xAA -> count stays 4; 0xAA later emerges after the three older words.
REQ-039 FWFT=1, empty, write 0x5C -> next cycle valid=1, dout=0x5C without rd_en; rd_en -> empty=1, valid=0.
REQ-040 Empty, rd_en=1 -> underflow=1, count=0; clr -> underflow=0, count=0, empty=1; rst mid-stream with count=3 -> all REQ-030 values.
REQ-041 DEPTH=8, AFULL_TH=6, AEMPTY_TH=2: sweep count 0..8 -> almost_empty 1 only for 0..2, almost_full 1 only for 6..8.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy counter width: must hold values 0..depth inclusive.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_pw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int PW   = fifo_pw(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  localparam int CW       = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = fifo_pw(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flex: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be >= 2");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rd;

  // Flags decode registered count only, so no input reaches a status output.
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign empty        = (count == '0);
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign ram_we = wr_acc && !rst && !clr;

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_addr(rd_ptr),
    .rd_data(ram_rd)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented combinationally; forced to zero while nothing is stored.
    assign dout  = empty ? '0 : ram_rd;
    assign valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_p1;
    logic             valid_p1;

    // Stage 1: registered read data, valid for exactly one cycle per accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_p1  <= '0;
        valid_p1 <= 1'b0;
      end else if (clr) begin
        valid_p1 <= 1'b0;
      end else begin
        valid_p1 <= rd_acc;
        if (rd_acc) dout_p1 <= ram_rd;
      end
    end

    assign dout  = dout_p1;
    assign valid = valid_p1;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives five FIFO configurations from shared stimulus and checks each against a queue model.
module tb_sync_fifo_flex;

  localparam int NI = 5;
  localparam int DEPS [NI] = '{4, 5, 4, 8, 5};
  localparam int FW   [NI] = '{0, 0, 1, 0, 1};
  localparam int AF   [NI] = '{3, 4, 3, 6, 5};
  localparam int AE   [NI] = '{1, 1, 1, 2, 0};

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0]  dout_a   [NI];
  logic        valid_a  [NI];
  logic        full_a   [NI];
  logic        afull_a  [NI];
  logic        empty_a  [NI];
  logic        aempty_a [NI];
  logic        ov_a     [NI];
  logic        un_a     [NI];
  logic [31:0] cnt_a    [NI];

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = DEPS[g];
    logic [$clog2(D+1)-1:0] cnt;
    sync_fifo_flex #(
      .WIDTH(8), .DEPTH(D), .FWFT(FW[g]), .AFULL_TH(AF[g]), .AEMPTY_TH(AE[g])
    ) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din),
      .full(full_a[g]), .almost_full(afull_a[g]), .rd_en(rd_en),
      .dout(dout_a[g]), .valid(valid_a[g]), .empty(empty_a[g]),
      .almost_empty(aempty_a[g]), .count(cnt), .overflow(ov_a[g]),
      .underflow(un_a[g])
    );
    assign cnt_a[g] = 32'(cnt);
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] t=%0t got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: a queue of stored words per configuration plus sticky flags.
  logic [7:0] mq [NI][$];
  logic [7:0] m_dout  [NI];
  bit         m_valid [NI];
  bit         m_ov    [NI];
  bit         m_un    [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int   sz;
      bit   ra, wa;
      logic [7:0] pv;
      sz = mq[i].size();
      if (rst) begin
        mq[i].delete();
        m_dout[i] = 8'h00; m_valid[i] = 0; m_ov[i] = 0; m_un[i] = 0;
      end else if (clr) begin
        mq[i].delete();
        m_valid[i] = 0; m_ov[i] = 0; m_un[i] = 0;
      end else begin
        ra = rd_en && (sz > 0);
        wa = wr_en && ((sz < DEPS[i]) || ra);
        if (rd_en && sz == 0) m_un[i] = 1;
        if (wr_en && !wa)     m_ov[i] = 1;
        pv = 8'h00;
        if (ra) pv = mq[i].pop_front();
        if (wa) mq[i].push_back(din);
        m_valid[i] = ra;
        if (ra) m_dout[i] = pv;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        int c;
        c = mq[i].size();
        chk("count",        i, cnt_a[i],    32'(c));
        chk("full",         i, 32'(full_a[i]),   32'(c == DEPS[i]));
        chk("almost_full",  i, 32'(afull_a[i]),  32'(c >= AF[i]));
        chk("empty",        i, 32'(empty_a[i]),  32'(c == 0));
        chk("almost_empty", i, 32'(aempty_a[i]), 32'(c <= AE[i]));
        chk("overflow",     i, 32'(ov_a[i]),     32'(m_ov[i]));
        chk("underflow",    i, 32'(un_a[i]),     32'(m_un[i]));
        if (FW[i] == 1) begin
          chk("valid", i, 32'(valid_a[i]), 32'(c > 0));
          if (c > 0) chk("dout", i, 32'(dout_a[i]), 32'(mq[i][0]));
        end else begin
          chk("valid", i, 32'(valid_a[i]), 32'(m_valid[i]));
          chk("dout",  i, 32'(dout_a[i]),  32'(m_dout[i]));
        end
      end
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [7:0] d);
    #1;
    rst = 0; clr = 0; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clr();
    #1;
    rst = 0; clr = 1; wr_en = 1; rd_en = 1; din = 8'h77;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rst();
    #1;
    rst = 1; clr = 0; wr_en = 1; rd_en = 0; din = 8'h99;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},  0, cnt_a[0], 0);
    chk({tag, "_empty"},  0, 32'(empty_a[0]), 1);
    chk({tag, "_aempty"}, 0, 32'(aempty_a[0]), 1);
    chk({tag, "_full"},   0, 32'(full_a[0]), 0);
    chk({tag, "_afull"},  0, 32'(afull_a[0]), 0);
    chk({tag, "_valid"},  0, 32'(valid_a[0]), 0);
    chk({tag, "_dout"},   0, 32'(dout_a[0]), 0);
    chk({tag, "_ovf"},    0, 32'(ov_a[0]), 0);
    chk({tag, "_unf"},    0, 32'(un_a[0]), 0);
  endtask

  logic [7:0] exp_rd  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_rd2 [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hAA};
  bit         ae_tab  [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
  bit         af_tab  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int pw, pr;
    rst = 1; clr = 0; wr_en = 0; rd_en = 0; din = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    cyc(0, 0, 8'h00);
    chk_reset_state("rst");
    chk("fwft_rst_dout",  2, 32'(dout_a[2]), 0);
    chk("fwft_rst_valid", 2, 32'(valid_a[2]), 0);

    // Fill four entries, then overflow the depth-4 FIFO.
    cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); cyc(1, 0, 8'h44);
    chk("fill_full",    0, 32'(full_a[0]), 1);
    chk("fill_count",   0, cnt_a[0], 4);
    chk("model_size",   0, 32'(mq[0].size()), 4);
    chk("model_head",   0, 32'(mq[0][0]), 32'h11);
    chk("fwft_head",    2, 32'(dout_a[2]), 32'h11);
    chk("fwft_valid",   2, 32'(valid_a[2]), 1);
    chk("d8_count",     3, cnt_a[3], 4);
    chk("d8_full",      3, 32'(full_a[3]), 0);
    cyc(1, 0, 8'h55);
    chk("ovf_set",      0, 32'(ov_a[0]), 1);
    chk("ovf_count",    0, cnt_a[0], 4);
    chk("d5_full",      1, 32'(full_a[1]), 1);
    chk("d5_count",     1, cnt_a[1], 5);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'h00);
      chk("rd_valid", 0, 32'(valid_a[0]), 1);
      chk("rd_dout",  0, 32'(dout_a[0]), 32'(exp_rd[k]));
    end
    cyc(0, 0, 8'h00);
    chk("rd_valid_drop", 0, 32'(valid_a[0]), 0);
    chk("rd_dout_hold",  0, 32'(dout_a[0]), 32'h44);
    chk("rd_empty",      0, 32'(empty_a[0]), 1);
    chk("d5_last",       4, 32'(dout_a[4]), 32'h55);

    // Underflow on empty, then flush.
    cyc(0, 1, 8'h00);
    chk("unf_set",   0, 32'(un_a[0]), 1);
    chk("unf_count", 0, cnt_a[0], 0);
    chk("d5_no_unf", 1, 32'(un_a[1]), 0);
    do_clr();
    chk("clr_unf",   0, 32'(un_a[0]), 0);
    chk("clr_ovf",   0, 32'(ov_a[0]), 0);
    chk("clr_count", 0, cnt_a[0], 0);
    chk("clr_empty", 0, 32'(empty_a[0]), 1);
    chk("clr_d8",    3, cnt_a[3], 0);

    // Simultaneous read and write while full.
    cyc(1, 0, 8'hA1); cyc(1, 0, 8'hA2); cyc(1, 0, 8'hA3); cyc(1, 0, 8'hA4);
    cyc(1, 1, 8'hAA);
    chk("rw_full_count", 0, cnt_a[0], 4);
    chk("rw_full_flag",  0, 32'(full_a[0]), 1);
    chk("rw_full_ovf",   0, 32'(ov_a[0]), 0);
    chk("rw_full_dout",  0, 32'(dout_a[0]), 32'hA1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 8'h00);
      chk("rw_drain", 0, 32'(dout_a[0]), 32'(exp_rd2[k]));
    end
    do_clr();

    // First-word-fall-through presentation.
    cyc(1, 0, 8'h5C);
    chk("fwft_valid1", 2, 32'(valid_a[2]), 1);
    chk("fwft_dout1",  2, 32'(dout_a[2]), 32'h5C);
    chk("std_novalid", 0, 32'(valid_a[0]), 0);
    cyc(0, 1, 8'h00);
    chk("fwft_empty2", 2, 32'(empty_a[2]), 1);
    chk("fwft_valid2", 2, 32'(valid_a[2]), 0);

    // Reset in the middle of a stream.
    cyc(0, 1, 8'h00);
    cyc(1, 0, 8'h31); cyc(1, 0, 8'h32); cyc(1, 0, 8'h33);
    chk("pre_rst_count", 0, cnt_a[0], 3);
    chk("pre_rst_unf",   0, 32'(un_a[0]), 1);
    do_rst();
    chk_reset_state("midrst");
    cyc(1, 0, 8'h61);
    cyc(0, 1, 8'h00);
    chk("post_rst_first", 0, 32'(dout_a[0]), 32'h61);

    // Threshold sweep on the depth-8 FIFO.
    cyc(0, 0, 8'h00);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) cyc(1, 0, 8'(8'hC0 + k));
      chk("sweep_count", 3, cnt_a[3], 32'(k));
      chk("sweep_aempty", 3, 32'(aempty_a[3]), 32'(ae_tab[k]));
      chk("sweep_afull",  3, 32'(afull_a[3]), 32'(af_tab[k]));
    end

    // Randomised traffic across fill/drain/balanced regimes.
    pw = 50; pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(3))
          0: begin pw = 80; pr = 30; end
          1: begin pw = 30; pr = 80; end
          2: begin pw = 60; pr = 60; end
          default: begin pw = 95; pr = 95; end
        endcase
      end
      #1;
      wr_en = ($urandom_range(99) < pw);
      rd_en = ($urandom_range(99) < pr);
      din   = 8'($urandom);
      clr   = ($urandom_range(99) == 0);
      rst   = ($urandom_range(499) == 0);
      @(posedge clk);
      @(negedge clk);
    end
    cyc(0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
